reg_load_sched: RTL and testbench
=================================

Name: reg_load_sched

Overview:
- Parametrised register-file write scheduler that replaces the plain destination-load decoder.
- Decodes immediate (ALU) writes into registered one-hot load enables.
- Tracks deferred (memory) loads in an in-order pending FIFO with a per-register scoreboard, and arbitrates both sources onto a single write port.
- Sits between the control unit / memory interface and the register file.

Parameters:
NUM_REGS, 4, number of architectural registers (2..2**SEL_W)
SEL_W, 2, width of register select fields
DATA_W, 8, register data width
MAX_PEND, 2, deferred loads outstanding at once (FIFO depth, >=1)

Ports:
Clock  in  1  system clock, all state on rising edge
Reset_n  in  1  asynchronous active-low reset
Select  in  SEL_W  destination of immediate write
Load_DST  in  1  immediate write request
Wr_Data  in  DATA_W  immediate write data
Defer_Valid  in  1  deferred-load issue request
Defer_Select  in  SEL_W  destination of deferred load
Defer_Ready  out  1  issue accepted when Defer_Valid & Defer_Ready
Resp_Valid  in  1  memory response strobe (in issue order)
Resp_Data  in  DATA_W  memory response data
Stall  out  1  immediate write not accepted this cycle; upstream holds
Load_R  out  NUM_REGS  one-hot register load enables (registered)
Load_Data  out  DATA_W  data accompanying Load_R (registered)
Pending  out  NUM_REGS  scoreboard, bit i = deferred load outstanding to reg i
Err  out  1  sticky protocol error flag

Behaviour:
Reset (asynchronous, Reset_n low):
- Load_R=0, Load_Data=0, Pending=0, Err=0, FIFO empty.
- Stall and Defer_Ready are combinational and follow the rules below from the reset state.

Write port:
- Exactly one write per cycle.
- Load_R/Load_Data update on the clock edge after acceptance (latency 1).
- Load_R is zero in cycles with no accepted write.
- Load_R is never more than one-hot.

Arbitration (response wins):
- Resp_Valid with FIFO non-empty:
  - Pop the FIFO head (destination d).
  - Load_R <= one-hot(d), Load_Data <= Resp_Data.
  - Clear Pending[d].
- Immediate write accepted iff Load_DST & Select<NUM_REGS & !Pending[Select] & !(Resp_Valid & FIFO non-empty).
  - On acceptance: Load_R <= one-hot(Select), Load_Data <= Wr_Data.

Stall:
- Stall = Load_DST & Select<NUM_REGS & (Pending[Select] | (Resp_Valid & FIFO non-empty)).
- Pending[Select] is the registered value, so WAW ordering is preserved.

Deferred issue:
- Defer_Ready = FIFO not full & Defer_Select<NUM_REGS & !Pending[Defer_Select], using registered Pending.
- On accept: push Defer_Select, set Pending[Defer_Select]. No write-port activity.

Simultaneous events:
- Issue and response in the same cycle: both take effect; occupancy unchanged.
- An issue to the register being freed that cycle is rejected (Defer_Ready low); it succeeds the next cycle.
- Issue and accepted immediate write in the same cycle are independent.

FIFO:
- Circular, MAX_PEND entries.
- Read/write pointers wrap modulo MAX_PEND; separate occupancy count 0..MAX_PEND.
- Full: Defer_Ready=0.

Errors (Err set, held until reset, otherwise no state change):
- Resp_Valid with FIFO empty: response ignored.
- Load_DST with Select>=NUM_REGS: no load, no stall.
- Defer_Valid with Defer_Select>=NUM_REGS: not accepted.

Mid-operation reset:
- Discards all pending entries and clears the scoreboard.
- Responses arriving after reset are treated as unexpected and set Err.

Test Plan:
1. Immediate writes, defaults: Load_DST=1, Select=0..3, Wr_Data=8'hA0+i on consecutive cycles -> Load_R=4'b0001,0010,0100,1000 one cycle later with matching data; Stall=0 throughout.
2. Deferred round trip: issue Defer_Select=2 -> Pending=4'b0100. Load_DST to R2 -> Stall=1 until Resp_Valid with Resp_Data=8'h5C. Then Load_R=4'b0100/8'h5C, Pending=0, and the held write completes the following cycle.
3. Arbitration: Resp_Valid for R1 and Load_DST to R3 in the same cycle -> Load_R=4'b0010 with response data, Stall=1; R3 written on the next cycle.
4. FIFO full/wrap: MAX_PEND=2; issue R0,R1 -> Defer_Ready=0 for R2. Respond once, then issue R2, then respond twice -> writes R0,R1,R2 in order with pointers wrapped; Pending returns to 0.
5. Simultaneous issue/response: with R0 pending, issue R3 while responding to R0 -> both accepted, occupancy stays 1, Pending=4'b1000. An issue to R0 in that same cycle -> Defer_Ready=0.
6. Errors/reset: Resp_Valid with FIFO empty -> Err=1, Load_R=0. NUM_REGS=3 with Select=3 -> no load, Err=1. Reset_n pulsed low mid-operation -> outputs cleared immediately (asynchronous), Err=0.

Source files
------------

// File: rtl/reg_load_sched.sv
// Register-file write scheduler: arbitrates immediate ALU writes and in-order
// memory responses onto one registered write port, with a per-register scoreboard.
module reg_load_sched #(
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = 2,
    parameter int DATA_W   = 8,
    parameter int MAX_PEND = 2
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic [SEL_W-1:0]    Select,
    input  logic                Load_DST,
    input  logic [DATA_W-1:0]   Wr_Data,
    input  logic                Defer_Valid,
    input  logic [SEL_W-1:0]    Defer_Select,
    output logic                Defer_Ready,
    input  logic                Resp_Valid,
    input  logic [DATA_W-1:0]   Resp_Data,
    output logic                Stall,
    output logic [NUM_REGS-1:0] Load_R,
    output logic [DATA_W-1:0]   Load_Data,
    output logic [NUM_REGS-1:0] Pending,
    output logic                Err
);

    localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
    localparam int CNT_W = $clog2(MAX_PEND + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_PEND - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_PEND);
    localparam logic [SEL_W:0]   NREGS    = (SEL_W + 1)'(NUM_REGS);

    // Out-of-range selects decode to all-zero, so they never hit the scoreboard.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            v[i] = (sel == SEL_W'(i));
        end
        return v;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    logic [SEL_W-1:0]    mem_q [MAX_PEND];
    logic [SEL_W-1:0]    mem_d [MAX_PEND];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_REGS-1:0] load_r_q, load_r_d;
    logic [DATA_W-1:0]   load_data_q, load_data_d;
    logic                err_q, err_d;

    logic                sel_ok_s, dsel_ok_s, fifo_empty_s, fifo_full_s;
    logic                resp_fire_s, imm_acc_s, push_s;
    logic [NUM_REGS-1:0] sel_oh_s, dsel_oh_s, head_oh_s;

    // Handshake decode, arbitration and next-state computation.
    always_comb begin
        sel_oh_s     = onehot(Select);
        dsel_oh_s    = onehot(Defer_Select);
        head_oh_s    = onehot(mem_q[rd_ptr_q]);
        sel_ok_s     = ({1'b0, Select} < NREGS);
        dsel_ok_s    = ({1'b0, Defer_Select} < NREGS);
        fifo_empty_s = (count_q == '0);
        fifo_full_s  = (count_q == CNT_FULL);
        resp_fire_s  = Resp_Valid & ~fifo_empty_s;

        // Registered scoreboard gates both paths, so a freed register is only reusable next cycle.
        Stall       = Load_DST & sel_ok_s & ((|(pending_q & sel_oh_s)) | resp_fire_s);
        imm_acc_s   = Load_DST & sel_ok_s & ~(|(pending_q & sel_oh_s)) & ~resp_fire_s;
        Defer_Ready = ~fifo_full_s & dsel_ok_s & ~(|(pending_q & dsel_oh_s));
        push_s      = Defer_Valid & Defer_Ready;

        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        pending_d = pending_q;

        if (push_s) begin
            mem_d[wr_ptr_q] = Defer_Select;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (resp_fire_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, resp_fire_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        pending_d = (pending_q & ~(resp_fire_s ? head_oh_s : '0)) |
                    (push_s ? dsel_oh_s : '0);

        // Memory response owns the write port whenever it fires.
        if (resp_fire_s) begin
            load_r_d    = head_oh_s;
            load_data_d = Resp_Data;
        end else if (imm_acc_s) begin
            load_r_d    = sel_oh_s;
            load_data_d = Wr_Data;
        end else begin
            load_r_d    = '0;
            load_data_d = load_data_q;
        end

        err_d = err_q | (Resp_Valid & fifo_empty_s) | (Load_DST & ~sel_ok_s) |
                (Defer_Valid & ~dsel_ok_s);
    end

    // State register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < MAX_PEND; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            pending_q   <= '0;
            load_r_q    <= '0;
            load_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            load_r_q    <= load_r_d;
            load_data_q <= load_data_d;
            err_q       <= err_d;
        end
    end

    assign Load_R    = load_r_q;
    assign Load_Data = load_data_q;
    assign Pending   = pending_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_reg_load_sched.sv
// Self-checking bench for reg_load_sched: directed scenarios plus random traffic
// compared against a queue-based reference model; a NUM_REGS=3 instance covers bad selects.
module tb_reg_load_sched;

    localparam int NR = 4;
    localparam int SW = 2;
    localparam int DW = 8;
    localparam int MP = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [SW-1:0] sel, dsel;
    logic          ld, dv, rv;
    logic [DW-1:0] wd, rdata;
    logic          dready, stall, err;
    logic [NR-1:0] load_r, pending;
    logic [DW-1:0] load_data;

    logic [SW-1:0] sel3, dsel3;
    logic          ld3, dv3, rv3;
    logic [DW-1:0] wd3, rdata3;
    logic          dready3, stall3, err3;
    logic [2:0]    load_r3, pending3;
    logic [DW-1:0] load_data3;

    reg_load_sched #(.NUM_REGS(NR), .SEL_W(SW), .DATA_W(DW), .MAX_PEND(MP)) dut (
        .Clock(clk), .Reset_n(rst_n), .Select(sel), .Load_DST(ld), .Wr_Data(wd),
        .Defer_Valid(dv), .Defer_Select(dsel), .Defer_Ready(dready),
        .Resp_Valid(rv), .Resp_Data(rdata), .Stall(stall), .Load_R(load_r),
        .Load_Data(load_data), .Pending(pending), .Err(err)
    );

    reg_load_sched #(.NUM_REGS(3), .SEL_W(SW), .DATA_W(DW), .MAX_PEND(MP)) dut3 (
        .Clock(clk), .Reset_n(rst_n), .Select(sel3), .Load_DST(ld3), .Wr_Data(wd3),
        .Defer_Valid(dv3), .Defer_Select(dsel3), .Defer_Ready(dready3),
        .Resp_Valid(rv3), .Resp_Data(rdata3), .Stall(stall3), .Load_R(load_r3),
        .Load_Data(load_data3), .Pending(pending3), .Err(err3)
    );

    // Reference model: outstanding loads as a queue of register numbers.
    int          q[$];
    bit [NR-1:0] m_pend;
    bit          m_err;
    logic [NR-1:0] m_lr;
    logic [DW-1:0] m_ld;

    int passes = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_pend = '0;
        m_err  = 1'b0;
        m_lr   = '0;
        m_ld   = '0;
    endtask

    // One clock cycle on the main instance, entered and left at a falling edge.
    task automatic cyc(input logic l, input logic [SW-1:0] s, input logic [DW-1:0] w,
                       input logic d, input logic [SW-1:0] ds,
                       input logic r, input logic [DW-1:0] rd);
        bit fire, e_stall, e_ready;
        int h;
        ld = l; sel = s; wd = w; dv = d; dsel = ds; rv = r; rdata = rd;
        #1;
        fire    = r && (q.size() > 0);
        e_stall = l && (m_pend[s] || fire);
        e_ready = (q.size() < MP) && !m_pend[ds];
        chk("stall", stall, e_stall);
        chk("defer_ready", dready, e_ready);
        if (r && q.size() == 0) m_err = 1'b1;
        if (fire) begin
            h = q.pop_front();
            m_lr = NR'(1) << h;
            m_ld = rd;
            m_pend[h] = 1'b0;
        end else if (l && !e_stall) begin
            m_lr = NR'(1) << s;
            m_ld = w;
        end else begin
            m_lr = '0;
        end
        if (d && e_ready) begin
            q.push_back(int'(ds));
            m_pend[ds] = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("load_r", load_r, m_lr);
        chk("load_data", load_data, m_ld);
        chk("pending", pending, m_pend);
        chk("err", err, m_err);
        @(negedge clk);
    endtask

    initial begin
        ld = 0; sel = 0; wd = 0; dv = 0; dsel = 0; rv = 0; rdata = 0;
        ld3 = 0; sel3 = 0; wd3 = 0; dv3 = 0; dsel3 = 0; rv3 = 0; rdata3 = 0;
        model_reset();
        #1;
        chk("rst_load_r", load_r, 4'b0000);
        chk("rst_pending", pending, 4'b0000);
        chk("rst_err", err, 1'b0);
        chk("rst_ready", dready, 1'b1);
        chk("rst_stall", stall, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Immediate writes to every register on consecutive cycles.
        for (int i = 0; i < 4; i++) cyc(1, SW'(i), DW'(8'hA0 + i), 0, 0, 0, 0);
        chk("t1_last_load", load_r, 4'b1000);

        // Deferred round trip on R2 with a blocked immediate write.
        cyc(0, 0, 0, 1, 2, 0, 0);
        chk("t2_pending", pending, 4'b0100);
        cyc(1, 2, 8'h11, 0, 0, 0, 0);
        cyc(1, 2, 8'h11, 0, 0, 1, 8'h5C);
        chk("t2_resp_data", load_data, 8'h5C);
        cyc(1, 2, 8'h11, 0, 0, 0, 0);
        chk("t2_held_write", load_r, 4'b0100);

        // Response to R1 beats an immediate write to R3.
        cyc(0, 0, 0, 1, 1, 0, 0);
        cyc(1, 3, 8'h33, 0, 0, 1, 8'h77);
        chk("t3_resp_wins", load_r, 4'b0010);
        cyc(1, 3, 8'h33, 0, 0, 0, 0);

        // FIFO fill, full rejection, pointer wrap.
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 2, 0, 0);
        chk("t4_full_ready", dready, 1'b0);
        cyc(0, 0, 0, 0, 0, 1, 8'hC0);
        cyc(0, 0, 0, 1, 2, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 8'hC1);
        cyc(0, 0, 0, 0, 0, 1, 8'hC2);
        chk("t4_wrap_load", load_r, 4'b0100);
        chk("t4_pending_clear", pending, 4'b0000);

        // Simultaneous issue and response; issue to the register being freed.
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 3, 1, 8'hD0);
        chk("t5_pending", pending, 4'b1000);
        cyc(0, 0, 0, 1, 0, 1, 8'hD1);
        cyc(0, 0, 0, 1, 0, 1, 8'hD2);
        cyc(0, 0, 0, 0, 0, 1, 8'hD3);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Unexpected response.
        cyc(0, 0, 0, 0, 0, 1, 8'hEE);
        chk("t6_err", err, 1'b1);
        chk("t6_no_load", load_r, 4'b0000);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            cyc(logic'($urandom_range(0, 1)), SW'($urandom_range(0, 3)), DW'($urandom),
                logic'($urandom_range(0, 1)), SW'($urandom_range(0, 3)),
                logic'($urandom_range(0, 2) == 0), DW'($urandom));
        end

        // Mid-operation asynchronous reset with a load outstanding.
        cyc(0, 0, 0, 0, 0, 1, 8'h01);
        cyc(0, 0, 0, 0, 0, 1, 8'h02);
        cyc(1, 0, 8'h44, 1, 1, 0, 0);
        chk("t7_pre_pending", pending, 4'b0010);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t7_rst_load_r", load_r, 4'b0000);
        chk("t7_rst_pending", pending, 4'b0000);
        chk("t7_rst_err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 1, 8'h55);
        chk("t7_late_resp_err", err, 1'b1);

        // Out-of-range selects on the three-register instance.
        ld3 = 1; sel3 = 3; wd3 = 8'h99; dv3 = 1; dsel3 = 3;
        #1;
        chk("r3_stall", stall3, 1'b0);
        chk("r3_ready", dready3, 1'b0);
        @(posedge clk);
        #1;
        chk("r3_load_r", load_r3, 3'b000);
        chk("r3_pending", pending3, 3'b000);
        chk("r3_err", err3, 1'b1);
        @(negedge clk);
        sel3 = 2; dv3 = 0;
        @(posedge clk);
        #1;
        chk("r3_valid_load", load_r3, 3'b100);
        chk("r3_valid_data", load_data3, 8'h99);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
